// File: rtl/serial_pkg.sv
// Shared definitions for the serializer/deserializer pair: FSM state encoding
// and the bit-counter width helper.
package serial_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Modulo-N counter with terminal-count flag; synchronous clear beats increment.
// Registered count, tc decoded from the count; no backpressure of its own.
import serial_pkg::*;

module bit_counter #(
  parameter  int N  = 8,
  localparam int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: first bit one cycle after accept, N bits per word.
// load_ready is high when idle or on the last bit, so frames chain with no gap.
import serial_pkg::*;

module piso_serializer #(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_in,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sh_out,
  output logic         sh_valid,
  output logic         sh_last,
  output logic         busy
);

  localparam int CW = cnt_width(N);

  state_t         state, state_nxt;
  logic [N-1:0]   shreg;
  logic [CW-1:0]  cnt;
  logic           tc;
  logic           xfer;
  logic           shifting;
  logic           out_bit;

  assign shifting = (state == SHIFT);
  assign xfer     = load_valid && load_ready;
  assign out_bit  = (MSB_FIRST != 0) ? shreg[N-1] : shreg[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        load_ready = tc;
        if (tc && !load_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
    end else if (xfer) begin
      shreg <= data_in;
    end else if (shifting && !tc) begin
      shreg <= (MSB_FIRST != 0) ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};
    end
  end

  // Counter returns to 0 at end of frame so an idle block always sits at cnt == 0.
  bit_counter #(.N(N)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (xfer || (shifting && tc)),
    .inc (shifting && !tc),
    .cnt (cnt),
    .tc  (tc)
  );

  // Outputs decode registered state only.
  assign sh_valid = shifting;
  assign busy     = shifting;
  assign sh_out   = shifting && out_bit;
  assign sh_last  = shifting && tc;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: per-bit scoreboard plus table-driven word checks.
// An MSB-first and an LSB-first instance share clock and reset.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = '0;
  logic       load_valid = 1'b0;
  logic       load_ready, sh_out, sh_valid, sh_last, busy;
  logic [7:0] l_data = '0;
  logic       l_valid = 1'b0;
  logic       l_ready, l_out, l_vld, l_last, l_busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {logic b; logic last;} bit_t;
  bit_t       q_m[$], q_l[$];
  logic [7:0] rx_m[$], rx_l[$];
  logic [7:0] acc_m = '0, acc_l = '0;

  typedef struct {logic [7:0] data; logic [7:0] exp_word; int gap;} vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  piso_serializer #(.N(8), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .sh_out(sh_out), .sh_valid(sh_valid),
    .sh_last(sh_last), .busy(busy));

  piso_serializer #(.N(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .data_in(l_data), .load_valid(l_valid),
    .load_ready(l_ready), .sh_out(l_out), .sh_valid(l_vld),
    .sh_last(l_last), .busy(l_busy));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard for the MSB-first instance.
  always @(negedge clk) begin
    bit_t e;
    if (!rst) begin
      chk("rst_sh_out", {7'd0, sh_out}, 8'd0);
      chk("rst_sh_valid", {7'd0, sh_valid}, 8'd0);
      chk("rst_sh_last", {7'd0, sh_last}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_load_ready", {7'd0, load_ready}, 8'd1);
      q_m.delete();
      acc_m = '0;
    end else begin
      chk("sh_valid", {7'd0, sh_valid}, {7'd0, q_m.size() != 0});
      chk("busy", {7'd0, busy}, {7'd0, q_m.size() != 0});
      chk("load_ready", {7'd0, load_ready}, {7'd0, q_m.size() <= 1});
      if (q_m.size() != 0) begin
        e = q_m.pop_front();
        chk("sh_out", {7'd0, sh_out}, {7'd0, e.b});
        chk("sh_last", {7'd0, sh_last}, {7'd0, e.last});
      end else begin
        chk("idle_sh_out", {7'd0, sh_out}, 8'd0);
        chk("idle_sh_last", {7'd0, sh_last}, 8'd0);
      end
      if (sh_valid) begin
        acc_m = {acc_m[6:0], sh_out};
        if (sh_last) rx_m.push_back(acc_m);
      end
      if (load_valid && load_ready)
        for (int i = 0; i < 8; i++) q_m.push_back('{b: data_in[7-i], last: (i == 7)});
    end
  end

  // Scoreboard for the LSB-first instance.
  always @(negedge clk) begin
    bit_t e;
    if (!rst) begin
      chk("lsb_rst_valid", {7'd0, l_vld}, 8'd0);
      chk("lsb_rst_out", {7'd0, l_out}, 8'd0);
      q_l.delete();
      acc_l = '0;
    end else begin
      chk("lsb_sh_valid", {7'd0, l_vld}, {7'd0, q_l.size() != 0});
      chk("lsb_load_ready", {7'd0, l_ready}, {7'd0, q_l.size() <= 1});
      if (q_l.size() != 0) begin
        e = q_l.pop_front();
        chk("lsb_sh_out", {7'd0, l_out}, {7'd0, e.b});
        chk("lsb_sh_last", {7'd0, l_last}, {7'd0, e.last});
      end
      if (l_vld) begin
        acc_l = {l_out, acc_l[7:1]};
        if (l_last) rx_l.push_back(acc_l);
      end
      if (l_valid && l_ready)
        for (int i = 0; i < 8; i++) q_l.push_back('{b: l_data[i], last: (i == 7)});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d);
    bit ok = 1'b0;
    data_in = d;
    load_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (load_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 8'd0, 8'd1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_word(output logic [7:0] w);
    for (int i = 0; i < 40; i++) begin
      if (rx_m.size() != 0) break;
      step(1);
    end
    if (rx_m.size() == 0) begin
      chk("word_timeout", 8'd0, 8'd1);
      w = '0;
    end else begin
      w = rx_m.pop_front();
    end
  endtask

  initial begin
    logic [7:0] w;
    vecs[0] = '{8'hA5, 8'hA5, 0};
    vecs[1] = '{8'h3C, 8'h3C, 2};
    vecs[2] = '{8'h00, 8'h00, 1};
    vecs[3] = '{8'hFF, 8'hFF, 0};
    vecs[4] = '{8'h81, 8'h81, 3};
    vecs[5] = '{8'h5A, 8'h5A, 1};

    // Reset held with load_valid asserted: nothing may be accepted.
    load_valid = 1'b1;
    data_in = 8'hAA;
    step(5);
    load_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("post_rst_load_ready", {7'd0, load_ready}, 8'd1);
    step(3);
    chk("post_rst_no_frame", 8'(rx_m.size()), 8'd0);

    foreach (vecs[k]) begin
      send(vecs[k].data);
      wait_word(w);
      chk($sformatf("word_%0d", k), w, vecs[k].exp_word);
      step(vecs[k].gap);
    end

    // Back-to-back: valid held high across both frames.
    data_in = 8'hA5;
    load_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (load_ready) break;
    end
    step(1);
    data_in = 8'h3C;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (load_ready) break;
    end
    step(1);
    load_valid = 1'b0;
    wait_word(w);
    chk("b2b_first", w, 8'hA5);
    wait_word(w);
    chk("b2b_second", w, 8'h3C);
    step(2);

    // Busy rejection: 8'hFF offered during bits 2..6 must be dropped.
    send(8'hF0);
    step(1);
    data_in = 8'hFF;
    load_valid = 1'b1;
    step(5);
    load_valid = 1'b0;
    wait_word(w);
    chk("busy_reject_word", w, 8'hF0);
    step(4);
    chk("busy_reject_no_extra", 8'(rx_m.size()), 8'd0);
    chk("busy_reject_idle", {7'd0, sh_valid}, 8'd0);

    // Asynchronous reset during bit 3 of 8'hFF.
    send(8'hFF);
    step(2);
    rst = 1'b0;
    #1;
    chk("async_rst_sh_out", {7'd0, sh_out}, 8'd0);
    chk("async_rst_sh_valid", {7'd0, sh_valid}, 8'd0);
    step(2);
    rst = 1'b1;
    step(1);
    chk("async_rst_no_partial", 8'(rx_m.size()), 8'd0);
    send(8'h81);
    wait_word(w);
    chk("after_rst_word", w, 8'h81);
    step(2);

    // LSB-first instance.
    l_data = 8'h01;
    l_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (l_ready) break;
    end
    step(1);
    l_valid = 1'b0;
    chk("lsb_first_bit", {7'd0, l_out}, 8'd1);
    step(7);
    chk("lsb_last_bit_flag", {7'd0, l_last}, 8'd1);
    step(2);
    chk("lsb_word_count", 8'(rx_l.size()), 8'd1);
    if (rx_l.size() != 0) chk("lsb_word", rx_l.pop_front(), 8'h01);
    chk("lsb_idle", {7'd0, l_vld}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out transmitter that accepts an N-bit word over a valid/ready handshake and emits it one bit per clock on a serial line, with valid and last-bit qualifiers. It is the transmit end feeding the team's serial shift-register chain and deserializer blocks. It supports gapless back-to-back frames and either bit order.

## Interface
- `N`, default 8: word width in bits, ≥ 2.
- `MSB_FIRST`, default 1: 1 sends bit N-1 first; 0 sends bit 0 first.

Ports:
- `clk`  in  1  single system clock; all flops on the rising edge.
- `rst`  in  1  **asynchronous, active-low reset**.
- `data_in`  in  N  parallel word; sampled only on an accepting edge.
- `load_valid`  in  1  producer has a word on `data_in`.
- `load_ready`  out  1  serializer can accept a word this cycle.
- `sh_out`  out  1  serial data bit.
- `sh_valid`  out  1  `sh_out` carries a frame bit this cycle.
- `sh_last`  out  1  current bit is the final bit of the frame.
- `busy`  out  1  a frame is in progress; equals `sh_valid`.

## Operation
- FSM states are IDLE and SHIFT. Internal state is an N-bit shift register `shreg` and a bit counter `cnt`, which is $clog2(N) bits wide and counts 0..N-1.
- A transfer occurs on a rising edge when `load_valid && load_ready`.
- `load_ready` is combinational: it is 1 in IDLE, and 1 in SHIFT when `cnt == N-1`. It is 0 otherwise.
- **IDLE behaviour:**
  - `sh_out`, `sh_valid`, `sh_last` and `busy` are all 0.
  - On a transfer: load `shreg` with `data_in`, set `cnt` = 0, go to SHIFT.
- **SHIFT behaviour:**
  - `sh_out` is `shreg[N-1]` when `MSB_FIRST`=1, or `shreg[0]` when `MSB_FIRST`=0.
  - `sh_valid` = 1.
  - `sh_last` = (`cnt == N-1`).
  - On each edge with `cnt < N-1`: shift `shreg` toward the output end, zero-fill, and increment `cnt`.
- **End of frame, when `cnt == N-1` at an edge:**
  - With a transfer: reload `shreg`, set `cnt` = 0, stay in SHIFT. The next frame follows with no gap.
  - Without a transfer: go to IDLE.
- `load_valid` is ignored while `load_ready` = 0. `data_in` is don't-care outside the accepting edge. The producer may hold `load_valid` high across a busy frame.
- **Reset behaviour:**
  - While `rst` = 0: the FSM is in IDLE; `shreg`, `cnt`, `sh_out`, `sh_valid`, `sh_last` and `busy` are 0. No transfer can occur.
  - Reset asserted mid-frame aborts the frame immediately, without waiting for a clock. The remaining bits are discarded.
  - After release, the block behaves as freshly idle.
- `load_ready` reads 1 during reset, because the FSM is in IDLE. This is benign, since flops are held.

## Timing
- Latency: the first bit appears in the cycle after the accepting edge.
- Frame length: exactly N consecutive cycles with `sh_valid` = 1. `sh_last` is high in the Nth cycle only.
- Throughput: one word per N cycles when `load_valid` is held high. No idle bubble occurs between frames.
- Outputs are registered or decoded from registered state only. `sh_out`, `sh_valid` and `sh_last` have no combinational path from inputs.
- `load_ready` depends only on state. It has no combinational dependence on `load_valid`.

## Structure
- Shared package `serial_pkg`:
  - state encoding localparams `ST_IDLE`, `ST_SHIFT`.
  - counter-width helper based on $clog2(N), also used by the matching deserializer.
- Optional sub-module `bit_counter`: a modulo-N counter with a terminal-count output, reusable in the receive block.
- Everything else stays flat in `piso_serializer`.

## Test plan
All scenarios use N=8 and `MSB_FIRST`=1 unless stated.
- **Reset:** hold `rst`=0 for 5 clocks with `load_valid`=1 -> all outputs 0 and no transfer. After release, `load_ready`=1.
- **Single word:** `data_in`=8'hA5, one-cycle `load_valid` -> `sh_out` sequence 1,0,1,0,0,1,0,1 in cycles 1..8 after accept. `sh_last` is high in cycle 8 only. `sh_valid` is 0 in cycle 9.
- **Back-to-back:** 8'hA5 then 8'h3C, `load_valid` held high -> 16 contiguous valid bits A5 then 3C. `sh_last` is high at bits 8 and 16. `load_ready` pulses high only in cycles 8 and 16.
- **Busy rejection:** 8'hF0 accepted, then 8'hFF presented at bits 2..6 and dropped at bit 7 -> output is exactly F0, then return to idle. 8'hFF is never sent.
- **Reset mid-frame:** `rst` asserted asynchronously during bit 3 of 8'hFF -> `sh_out` and `sh_valid` go to 0 before the next edge. After release, load 8'h81 -> a clean 1,0,0,0,0,0,0,1 frame.
- **LSB-first:** build with `MSB_FIRST`=0, `data_in`=8'h01 -> first bit 1, next 7 bits 0, `sh_last` on bit 8.
